pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter: the generalised replacement for the single-cycle, left-only 32-bit shifter.
- Supports four modes: SLL, SRL, SRA and ROL.
- Data width N is parametrised. One register stage per shamt bit, with a valid/ready handshake on both sides.
- Sits between the ALU operand muxes and the writeback path for multi-cycle ALU ops.

Parameters:
- N, 32, data width; must be a power of 2, >= 4.
- L, $clog2(N), number of pipeline stages (derived; do not override).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- in_data  input  N  operand.
- in_shamt  input  L  shift amount, 0..N-1.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result when out_valid & out_ready.
- out_data  output  N  shifted result.
- busy  output  1  high if any stage holds a valid entry.

Behaviour:
- Reset: clk and rst only. rst high at a rising edge clears every stage valid bit, data, shamt and op register to 0.
  - Outputs after reset: out_valid=0, out_data=0, busy=0.
  - in_ready=1 after reset (follows from the stall rule below).
  - Reset mid-operation discards all in-flight entries; no result is emitted for them.
- Pipeline structure: stage k (k=0..L-1) registers {valid, data, remaining shamt, op}.
  - Stage k's input is stage k-1's output; stage 0's input is the in_* ports.
  - Stage k shifts by 2^k when shamt bit k is 1; otherwise it passes data unchanged.
  - Stage L-1's registers drive out_*.
- Mode rules at each stage, for a shift by s=2^k:
  - SLL: zeros fill the low bits.
  - SRL: zeros fill the high bits.
  - SRA: copies of data[N-1] of that stage's input fill the high bits (equivalent to the original sign bit).
  - ROL: bits shifted out of the top re-enter at the bottom.
- Result equals the single-cycle reference op on the original in_data and in_shamt. shamt=0 returns in_data unchanged in all modes.
- Stall rule: advance = !out_valid | out_ready; in_ready = advance (purely combinational).
  - When advance=1, every stage loads from its predecessor.
  - Stage 0 loads valid = in_valid.
  - When advance=0, all stages hold their contents.
  - Bubbles are not compressed.
- Latency: exactly L cycles from acceptance to out_valid with no backpressure. Throughput is 1 result per cycle.
- Ordering: results leave in acceptance order. No drops and no duplicates.
- out_data and out_valid are stable while out_valid=1 & out_ready=0.
- Simultaneous accept and emit in the same cycle is legal and required at full throughput.
- in_valid=1 while in_ready=0: the input is not captured. The producer must hold it.
- No combinational path from in_valid or in_data to any output. in_ready depends only on out_valid and out_ready.
- busy = OR of all stage valid bits.

Test Plan:
- Reset check: N=32; hold rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, busy=0, in_ready=1; the first result appears only 5 cycles after the first post-reset accept.
- Mode sweep: in_data=0x8000_00F1 and shamt=4, one per cycle for each mode, out_ready=1 -> outputs appear on consecutive cycles 5 cycles after their accepts, in order:
  - SLL: 0x0000_0F10
  - SRL: 0x0800_000F
  - SRA: 0xF800_000F
  - ROL: 0x0000_0F18
- Boundaries: shamt=0 all modes -> in_data. shamt=31 with in_data=0x8000_0001:
  - SLL: 0x8000_0000
  - SRL: 0x0000_0001
  - SRA: 0xFFFF_FFFF
  - ROL: 0xC000_0000
- Backpressure: stream 8 random requests; drop out_ready for 3 cycles when the first result appears -> in_ready=0 during the stall; outputs held stable; all 8 results correct, in order, none lost.
- Mid-op reset: accept 3 requests, assert rst for 1 cycle on cycle 2 -> no outputs for those requests; busy=0 next cycle; a new request completes in 5 cycles.
- Randomised scoreboard: 10k requests with random out_ready and in_valid, at N=8 and N=64 -> every output matches the behavioural model.

Source files
------------

// File: rtl/pipelined_shifter_if.sv
// Request/response bundle for the pipelined shifter.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds valid and its payload stable until then,
// and ready never depends combinationally on the same side's valid.
interface pipelined_shifter_if #(
  parameter int N = 32,
  parameter int L = $clog2(N)
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [L-1:0] in_shamt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL, SRL, SRA and ROL over N bits, one register
// stage per shift-amount bit. Stage k conditionally shifts by 2^k; the whole
// pipe advances together or stalls together (bubbles are kept).
module pipelined_shifter #(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  pipelined_shifter_if.slave bus
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // Stage registers
  logic [L-1:0] valid_q;
  logic [N-1:0] data_q  [L];
  logic [L-1:0] shamt_q [L];
  logic [1:0]   op_q    [L];

  // Stage inputs (predecessor outputs) and the shifted data each stage loads
  logic [L-1:0] src_valid;
  logic [N-1:0] src_data  [L];
  logic [L-1:0] src_shamt [L];
  logic [1:0]   src_op    [L];
  logic [N-1:0] shifted   [L];

  logic advance;

  // One fixed-distance shift step of 2^k in the requested mode. SRA fills
  // with this stage's input MSB, which is still the original sign bit.
  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d,
                                              input logic [1:0]   op,
                                              input int           k);
    int s;
    s = 1 << k;
    case (op)
      OP_SRL:  shift_step = d >> s;
      OP_SRA:  shift_step = $signed(d) >>> s;
      OP_ROL:  shift_step = (d << s) | (d >> (N - s));
      default: shift_step = d << s;
    endcase
  endfunction

  // The pipe may move whenever the last stage is empty or being drained.
  assign advance      = !valid_q[L-1] || bus.out_ready;
  assign bus.in_ready = advance;

  assign bus.out_valid = valid_q[L-1];
  assign bus.out_data  = data_q[L-1];
  assign bus.busy      = |valid_q;

  // Chain stage inputs and apply each stage's conditional shift.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_shamt[0] = bus.in_shamt;
    src_op[0]    = bus.in_op;
    for (int k = 1; k < L; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
    end
    for (int k = 0; k < L; k++) begin
      shifted[k] = src_shamt[k][k] ? shift_step(src_data[k], src_op[k], k)
                                   : src_data[k];
    end
  end

  // Stage registers: clear on reset, load together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
      end
    end else if (advance) begin
      valid_q <= src_valid;
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= shifted[k];
        shamt_q[k] <= src_shamt[k];
        op_q[k]    <= src_op[k];
      end
    end
  end

endmodule
